// File: rtl/line_peak_finder_if.sv
// Sample stream, line-start level, host handshake and result bus of line_peak_finder.
// The slave modport is the finder; the master modport is the ADC/host side.
interface line_peak_finder_if #(
    parameter int DW = 12,
    parameter int IW = 7
);
    logic          sample_control;
    logic          new_Data;
    logic [DW-1:0] pdata1;
    logic [DW-1:0] pdata2;
    logic [DW-1:0] threshold;
    logic          line_ack;
    logic          line_valid;
    logic [DW-1:0] peak1_val;
    logic [DW-1:0] peak2_val;
    logic [IW-1:0] peak1_idx;
    logic [IW-1:0] peak2_idx;
    logic          peak1_found;
    logic          peak2_found;
    logic          overrun;
    logic          short_line;
    logic          busy;

    modport master (
        output sample_control, new_Data, pdata1, pdata2, threshold, line_ack,
        input  line_valid, peak1_val, peak2_val, peak1_idx, peak2_idx,
               peak1_found, peak2_found, overrun, short_line, busy
    );

    modport slave (
        input  sample_control, new_Data, pdata1, pdata2, threshold, line_ack,
        output line_valid, peak1_val, peak2_val, peak1_idx, peak2_idx,
               peak1_found, peak2_found, overrun, short_line, busy
    );
endinterface

// File: rtl/line_peak_finder.sv
// Frames each sensor line on a synchronized sample_control rising edge, tracks per-channel
// peak value/index over PIXELS samples and hands one result set per line to the host.
module line_peak_finder #(
    parameter int PIXELS = 128,
    parameter int DW     = 12,
    parameter int IW     = 7
) (
    input logic               clk_20M,
    input logic               reset,
    line_peak_finder_if.slave bus
);
    typedef enum logic {IDLE, ACQ} state_t;

    state_t        state, state_next;
    logic          s1, s2, s3, start;
    logic          clear, take, complete, restart;
    logic          last_pix, ack_hit;
    logic [IW-1:0] pix, idx1, idx2, idx1_next, idx2_next;
    logic [DW-1:0] max1, max2, max1_next, max2_next;
    logic          line_valid, overrun, short_line;
    logic [DW-1:0] peak1_val, peak2_val;
    logic [IW-1:0] peak1_idx, peak2_idx;
    logic          peak1_found, peak2_found;

    // s1/s2 synchronize the asynchronous level; s3 delays it for rising-edge detection.
    always_ff @(posedge clk_20M) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            // NOTE: non-blocking so each flop takes its neighbour's pre-edge value; blocking
            // assignments here would collapse the three-stage chain into a single flop.
            s1 <= bus.sample_control;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign start    = s2 & ~s3;
    assign last_pix = (pix == IW'(PIXELS - 1));
    assign ack_hit  = bus.line_ack & line_valid;

    always_ff @(posedge clk_20M) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path through the case
        // leaves one unassigned and no latch is inferred.
        state_next = state;
        clear      = 1'b0;
        take       = 1'b0;
        complete   = 1'b0;
        restart    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = ACQ;
                    clear      = 1'b1;
                end
            end
            ACQ: begin
                if (start) begin
                    clear   = 1'b1;
                    restart = 1'b1;
                end else if (bus.new_Data) begin
                    take = 1'b1;
                    if (last_pix) begin
                        complete   = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Strict greater-than keeps the earliest index on ties.
    always_comb begin
        max1_next = max1;
        idx1_next = idx1;
        max2_next = max2;
        idx2_next = idx2;
        if (bus.pdata1 > max1) begin
            max1_next = bus.pdata1;
            idx1_next = pix;
        end
        if (bus.pdata2 > max2) begin
            max2_next = bus.pdata2;
            idx2_next = pix;
        end
    end

    always_ff @(posedge clk_20M) begin
        if (reset || clear) begin
            pix  <= '0;
            max1 <= '0;
            max2 <= '0;
            idx1 <= '0;
            idx2 <= '0;
        end else if (take) begin
            pix  <= last_pix ? '0 : pix + IW'(1);
            max1 <= max1_next;
            max2 <= max2_next;
            idx1 <= idx1_next;
            idx2 <= idx2_next;
        end
    end

    always_ff @(posedge clk_20M) begin
        if (reset) begin
            line_valid  <= 1'b0;
            overrun     <= 1'b0;
            short_line  <= 1'b0;
            peak1_val   <= '0;
            peak2_val   <= '0;
            peak1_idx   <= '0;
            peak2_idx   <= '0;
            peak1_found <= 1'b0;
            peak2_found <= 1'b0;
        end else begin
            if (complete) begin
                peak1_val   <= max1_next;
                peak2_val   <= max2_next;
                peak1_idx   <= idx1_next;
                peak2_idx   <= idx2_next;
                peak1_found <= (max1_next >= bus.threshold);
                peak2_found <= (max2_next >= bus.threshold);
                line_valid  <= 1'b1;
                if (line_valid) overrun    <= 1'b1;
                if (ack_hit)    short_line <= 1'b0;
            end else if (ack_hit) begin
                line_valid <= 1'b0;
                overrun    <= 1'b0;
                short_line <= 1'b0;
            end
            if (restart) short_line <= 1'b1;
        end
    end

    assign bus.busy        = (state == ACQ);
    assign bus.line_valid  = line_valid;
    assign bus.overrun     = overrun;
    assign bus.short_line  = short_line;
    assign bus.peak1_val   = peak1_val;
    assign bus.peak2_val   = peak2_val;
    assign bus.peak1_idx   = peak1_idx;
    assign bus.peak2_idx   = peak2_idx;
    assign bus.peak1_found = peak1_found;
    assign bus.peak2_found = peak2_found;
endmodule
